// File: rtl/alu_op_sequencer.sv
// Command-side sequencer for a shared single-adder ALU: single-step ops, NEG,
// and an iterative shift-add MUL, behind valid/ready command and response ports.
module alu_op_sequencer #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [DW-1:0] cmd_a,
  input  logic [DW-1:0] cmd_b,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [1:0]    alu_control,
  input  logic [DW-1:0] alu_y,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_NEG = 3'b101;

  typedef enum logic [1:0] {IDLE, EXEC, MUL_ITER, RESP} state_t;

  state_t        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [DW-1:0] a_q, a_d;        // doubles as the shifting multiplicand
  logic [DW-1:0] b_q, b_d;        // doubles as the shifting multiplier
  logic [DW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic          rsp_err_q, rsp_err_d;
  logic [DW-1:0] acc_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    acc_next    = acc_q;
    cmd_ready   = 1'b0;
    rsp_valid   = 1'b0;
    alu_a       = '0;
    alu_b       = '0;
    alu_control = 2'b00;

    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d    = cmd_op;
          a_d     = cmd_a;
          b_d     = cmd_b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = (cmd_op == OP_MUL) ? MUL_ITER : EXEC;
        end
      end

      EXEC: begin
        rsp_err_d = 1'b0;
        unique case (op_q)
          OP_ADD: begin alu_a = a_q; alu_b = b_q; alu_control = 2'b00; end
          OP_SUB: begin alu_a = a_q; alu_b = b_q; alu_control = 2'b01; end
          OP_AND: begin alu_a = a_q; alu_b = b_q; alu_control = 2'b10; end
          OP_OR:  begin alu_a = a_q; alu_b = b_q; alu_control = 2'b11; end
          OP_NEG: begin alu_a = '0;  alu_b = a_q; alu_control = 2'b01; end
          default: rsp_err_d = 1'b1;
        endcase
        rsp_data_d = rsp_err_d ? '0 : alu_y;
        state_d    = RESP;
      end

      MUL_ITER: begin
        alu_a       = acc_q;
        alu_b       = a_q;
        alu_control = 2'b00;
        acc_next    = b_q[0] ? alu_y : acc_q;
        acc_d       = acc_next;
        a_d         = a_q << 1;
        b_d         = b_q >> 1;
        cnt_d       = cnt_q + CW'(1);
        // Fixed DW iterations regardless of operand values.
        if (cnt_q == CW'(DW - 1)) begin
          rsp_data_d = acc_next;
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end
      end

      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;

endmodule
